// File: rtl/serial_pattern_tx_if.sv
// Load handshake, pacing and serial-output bundle for serial_pattern_tx.
// The master side drives the transmitter; the slave side is the transmitter.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
) ();
  logic             tick;
  logic [WIDTH-1:0] pattern;
  logic             load;
  logic             load_ack;
  logic             rpt;
  logic             stop;
  logic             q;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [7:0]       frame_cnt;
  logic [7:0]       exp_hits;

  modport master (
    output tick, pattern, load, rpt, stop,
    input  load_ack, q, bit_valid, busy, done, frame_cnt, exp_hits
  );

  modport slave (
    input  tick, pattern, load, rpt, stop,
    output load_ack, q, bit_valid, busy, done, frame_cnt, exp_hits
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Shifts a loaded pattern out MSB-first, one bit per tick, with optional
// back-to-back repeat; counts finished frames and 1101 strings put on q.
//
// state | meaning
// IDLE  | waiting for load; tick ignored
// ARM   | pattern latched, first bit goes out on next tick
// SHIFT | bits going out; tick after the last bit closes the frame
module serial_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_pattern_tx_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n, shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             stop_req, stop_req_n;
  logic [3:0]       hist, hist_n;
  logic [7:0]       fcnt, fcnt_n, hits, hits_n;
  logic             q_r, q_n, ack_r, ack_n, bv_r, bv_n, done_r, done_n;
  logic             emit, ebit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      shreg    <= '0;
      cnt      <= '0;
      stop_req <= 1'b0;
      hist     <= 4'd0;
      fcnt     <= 8'd0;
      hits     <= 8'd0;
      q_r      <= 1'b0;
      ack_r    <= 1'b0;
      bv_r     <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      stop_req <= stop_req_n;
      hist     <= hist_n;
      fcnt     <= fcnt_n;
      hits     <= hits_n;
      q_r      <= q_n;
      ack_r    <= ack_n;
      bv_r     <= bv_n;
      done_r   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    shadow_n   = shadow;
    shreg_n    = shreg;
    cnt_n      = cnt;
    stop_req_n = stop_req;
    hist_n     = hist;
    fcnt_n     = fcnt;
    hits_n     = hits;
    q_n        = q_r;
    ack_n      = 1'b0;
    bv_n       = 1'b0;
    done_n     = 1'b0;
    emit       = 1'b0;
    ebit       = 1'b0;

    if ((state != IDLE) && bus.stop)
      stop_req_n = 1'b1;

    case (state)
      IDLE: begin
        if (bus.load) begin
          shadow_n = bus.pattern;
          ack_n    = 1'b1;
          state_n  = ARM;
        end
      end
      ARM: begin
        if (bus.tick) begin
          emit    = 1'b1;
          ebit    = shadow[WIDTH-1];
          shreg_n = shadow << 1;
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.tick) begin
          if (cnt < CW'(WIDTH)) begin
            emit    = 1'b1;
            ebit    = shreg[WIDTH-1];
            shreg_n = shreg << 1;
            cnt_n   = cnt + 1'b1;
          end else begin
            done_n = 1'b1;
            fcnt_n = fcnt + 8'd1;
            // a stop arriving on the boundary tick itself still ends the run
            if (bus.rpt && !stop_req && !bus.stop) begin
              emit    = 1'b1;
              ebit    = shadow[WIDTH-1];
              shreg_n = shadow << 1;
              cnt_n   = CW'(1);
            end else begin
              q_n        = 1'b0;
              state_n    = IDLE;
              stop_req_n = 1'b0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (emit) begin
      q_n    = ebit;
      bv_n   = 1'b1;
      hist_n = {hist[2:0], ebit};
      if ((hist_n == 4'b1101) && (hits != 8'hFF))
        hits_n = hits + 8'd1;
    end
  end

  assign bus.q         = q_r;
  assign bus.load_ack  = ack_r;
  assign bus.bit_valid = bv_r;
  assign bus.done      = done_r;
  assign bus.busy      = (state != IDLE);
  assign bus.frame_cnt = fcnt;
  assign bus.exp_hits  = hits;
endmodule
